alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_sel  input  5  [0] invert a, [1] invert b, [4:2] op: 001 OR, 010 AND, 011 XOR, 100 ADD, 101 SHR, 110 SHL.
REQ-008 cmd_a, cmd_b  input  64  operands.
REQ-009 cmd_cin  input  1  adder carry-in.
REQ-010 res_valid  output  1  result held and valid.
REQ-011 res_ready  input  1  consumer takes result.
REQ-012 res_out  output  64  result.
REQ-013 res_cout  output  1  adder carry-out.
REQ-014 res_status  output  4  {N,V,Z,C} as bits [3:0] = N,V,Z,C ordered status[0]=C, [1]=Z, [2]=V, [3]=N.
REQ-015 res_err  output  1  illegal op code.
REQ-016 op_count  output  CNT_W  completed result handshakes.

Function
REQ-017 FSM states IDLE, EXEC, HOLD; command accepted on edge where cmd_valid & cmd_ready.
REQ-018 cmd_ready = (state==IDLE) | (state==HOLD & res_ready); accepted operands, sel, cin registered at acceptance.
REQ-019 Accept moves FSM to EXEC and loads shift counter with b[5:0] for SHR/SHL, else 0.
REQ-020 EXEC with counter != 0 (shift ops): shift working register one bit per cycle (logical, zero fill), decrement counter.
REQ-021 EXEC with counter == 0: compute result, register all res_* outputs, go HOLD; res_valid=1 while HOLD.
REQ-022 Latency: accept at edge N -> res_valid high after edge N+1+k, k = shift amount for shifts, 0 otherwise.
REQ-023 a_eff = sel[0] ? ~a : a; b_eff = sel[1] ? ~b : b; OR/AND/XOR operate on a_eff, b_eff.
REQ-024 ADD: {res_cout,res_out} = a_eff + b_eff + cin, 65-bit; subtraction is sel[1]=1, cin=1.
REQ-025 SHR/SHL operate on un-inverted a by b[5:0]; sel[1:0] ignored; amount 0 yields a.
REQ-026 C = res_cout for ADD, else 0; res_cout = 0 for non-ADD.
REQ-027 V = ADD & (a_eff[63]==b_eff[63]) & (res_out[63]!=a_eff[63]); 0 otherwise.
REQ-028 Z = (res_out==0); N = res_out[63] for all legal ops.
REQ-029 Op codes 000, 111: res_out=0, res_status=0000, res_cout=0, res_err=1, latency 1 cycle; res_err=0 for legal ops.
REQ-030 HOLD with res_ready=0: all res_* outputs stable, cmd_ready=0, cmd inputs ignored.
REQ-031 HOLD with res_ready=1, cmd_valid=0: go IDLE, res_valid=0 next cycle.
REQ-032 HOLD with res_ready=1, cmd_valid=1: result retired and new command accepted same edge, go EXEC.
REQ-033 op_count increments by 1 on each res_valid & res_ready edge; wraps all-ones to 0.
REQ-034 Command inputs changing during EXEC have no effect on the in-flight operation.

Reset
REQ-035 rst_n low: state IDLE, res_valid=0, res_out=0, res_cout=0, res_status=0, res_err=0, op_count=0, shift counter=0, immediately and asynchronously.
REQ-036 Reset asserted mid-EXEC (including mid-shift) or in HOLD: operation discarded, no op_count increment.
REQ-037 cmd_ready=1 on first clock edge after rst_n deasserts.

Verification
REQ-038 ADD a=5,b=3,sel=10000,cin=0 -> res_out=8, status=0000, res_valid after edge N+1.
REQ-039 SUB a=3,b=5,sel=10010,cin=1 -> res_out=FFFF_FFFF_FFFF_FFFE, status=1000, cout=0.
REQ-040 ADD a=7FFF_FFFF_FFFF_FFFF,b=1 -> res_out=8000_0000_0000_0000, status=1100.
REQ-041 SHL a=1,b=63,sel=11000 -> res_out=8000_0000_0000_0000, status=1000, res_valid after edge N+64; reset at N+30 -> IDLE, op_count unchanged.
REQ-042 XOR a=b=DEAD,sel=01100 -> res_out=0, status=0010; hold res_ready=0 5 cycles -> outputs stable, cmd_ready=0; then res_ready=1 with cmd_valid=1 -> accept same edge, op_count +1.
REQ-043 sel=00000 -> res_err=1, res_out=0, status=0000; op_count from FFFF plus one handshake -> 0000.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle 64-bit ALU with a valid/ready command port and a
// valid/ready result port.
//
// A command is accepted on any edge where cmd_valid & cmd_ready. It then spends
// one cycle in EXEC, plus one extra cycle per bit for SHR/SHL. The result is
// held in HOLD until the consumer takes it.
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   sequencer accepts a command this cycle
//   cmd_sel     [0] invert a, [1] invert b, [4:2] op code
//               001 OR, 010 AND, 011 XOR, 100 ADD, 101 SHR, 110 SHL
//   cmd_a       operand a
//   cmd_b       operand b (b[5:0] is the shift amount for SHR/SHL)
//   cmd_cin     adder carry-in
//   res_valid   result held and valid
//   res_ready   consumer takes the result
//   res_out     64-bit result
//   res_cout    adder carry-out (0 for non-ADD ops)
//   res_status  flags: [3]=N, [2]=V, [1]=Z, [0]=C
//   res_err     illegal op code (000 or 111)
//   op_count    number of completed result handshakes, wraps
module alu_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_sel,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    input  logic             cmd_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_out,
    output logic             res_cout,
    output logic [3:0]       res_status,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpXor = 3'b011;
    localparam logic [2:0] OpAdd = 3'b100;
    localparam logic [2:0] OpShr = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    state_e      state_q;
    logic [63:0] a_q;          // operand a; doubles as the shift working register
    logic [63:0] b_q;
    logic [4:0]  sel_q;
    logic        cin_q;
    logic [5:0]  shift_cnt_q;

    logic        accept;
    logic [2:0]  op_q;
    logic        cmd_is_shift;
    logic [63:0] a_eff;
    logic [63:0] b_eff;
    logic [64:0] sum;
    logic [63:0] shift_step;
    logic [63:0] calc_out;
    logic        calc_cout;
    logic [3:0]  calc_status;
    logic        calc_err;

    // A new command can enter in the same edge the held result retires.
    assign cmd_ready = (state_q == StIdle) || ((state_q == StHold) && res_ready);
    assign accept    = cmd_valid && cmd_ready;

    assign op_q         = sel_q[4:2];
    assign cmd_is_shift = (cmd_sel[4:2] == OpShr) || (cmd_sel[4:2] == OpShl);

    assign a_eff = sel_q[0] ? ~a_q : a_q;
    assign b_eff = sel_q[1] ? ~b_q : b_q;
    assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {64'd0, cin_q};

    // Shifts are logical with zero fill, one bit per EXEC cycle.
    assign shift_step = (op_q == OpShr) ? (a_q >> 1) : (a_q << 1);

    always_comb begin
        calc_out    = 64'd0;
        calc_cout   = 1'b0;
        calc_status = 4'b0000;
        calc_err    = 1'b0;
        unique case (op_q)
            OpOr:  calc_out = a_eff | b_eff;
            OpAnd: calc_out = a_eff & b_eff;
            OpXor: calc_out = a_eff ^ b_eff;
            OpAdd: begin
                calc_out  = sum[63:0];
                calc_cout = sum[64];
            end
            // By now the working register already holds the fully shifted value.
            OpShr, OpShl: calc_out = a_q;
            default: calc_err = 1'b1;
        endcase
        if (!calc_err) begin
            calc_status[3] = calc_out[63];
            calc_status[2] = (op_q == OpAdd) && (a_eff[63] == b_eff[63])
                             && (calc_out[63] != a_eff[63]);
            calc_status[1] = (calc_out == 64'd0);
            calc_status[0] = calc_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= 64'd0;
            b_q         <= 64'd0;
            sel_q       <= 5'd0;
            cin_q       <= 1'b0;
            shift_cnt_q <= 6'd0;
            res_valid   <= 1'b0;
            res_out     <= 64'd0;
            res_cout    <= 1'b0;
            res_status  <= 4'b0000;
            res_err     <= 1'b0;
            op_count    <= '0;
        end else begin
            if (res_valid && res_ready) begin
                op_count <= op_count + CntOne;
            end

            if (accept) begin
                a_q         <= cmd_a;
                b_q         <= cmd_b;
                sel_q       <= cmd_sel;
                cin_q       <= cmd_cin;
                shift_cnt_q <= cmd_is_shift ? cmd_b[5:0] : 6'd0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (shift_cnt_q != 6'd0) begin
                        a_q         <= shift_step;
                        shift_cnt_q <= shift_cnt_q - 6'd1;
                    end else begin
                        res_out    <= calc_out;
                        res_cout   <= calc_cout;
                        res_status <= calc_status;
                        res_err    <= calc_err;
                        res_valid  <= 1'b1;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= accept ? StExec : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
module tb_alu_sequencer;

    // Narrow counter keeps the wrap-around scenario short.
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_sel;
    logic [63:0]      cmd_a;
    logic [63:0]      cmd_b;
    logic             cmd_cin;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_out;
    logic             res_cout;
    logic [3:0]       res_status;
    logic             res_err;
    logic [CNT_W-1:0] op_count;

    int               checks;
    int               fails;
    logic [CNT_W-1:0] exp_count;

    alu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_out    (res_out),
        .res_cout   (res_cout),
        .res_status (res_status),
        .res_err    (res_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; everything is driven and sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] sel, input logic [63:0] a, input logic [63:0] b,
                        input logic cin);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
    endtask

    task automatic retire();
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        step();
        res_ready = 1'b0;
        exp_count = exp_count + 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++; if (res_out !== 64'd0) begin fails++; $display("FAIL reset_out: got %h want 0", res_out); end
        checks++; if (res_status !== 4'b0000 || res_cout !== 1'b0 || res_err !== 1'b0) begin
            fails++; $display("FAIL reset_flags: status=%b cout=%b err=%b want 0", res_status, res_cout, res_err);
        end
        checks++; if (op_count !== '0) begin fails++; $display("FAIL reset_count: got %h want 0", op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
        step();
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    typedef struct packed {
        logic [4:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] out;
        logic [3:0]  st;
        logic        cout;
    } arith_t;

    task automatic test_arith();
        arith_t v[9];
        v[0] = '{5'b10000, 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 1'b0};
        v[1] = '{5'b10010, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0};
        v[2] = '{5'b10000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1100, 1'b0};
        v[3] = '{5'b10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0011, 1'b1};
        v[4] = '{5'b10010, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0011, 1'b1};
        v[5] = '{5'b10000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b0111, 1'b1};
        v[6] = '{5'b01001, 64'hFF00, 64'h0F0F, 1'b0, 64'h000F, 4'b0000, 1'b0};
        v[7] = '{5'b00110, 64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
        v[8] = '{5'b01111, 64'h1234, 64'h00FF, 1'b1, 64'h12CB, 4'b0000, 1'b0};
        for (int i = 0; i < 9; i++) begin
            send(v[i].sel, v[i].a, v[i].b, v[i].cin);
            step();
            cmd_valid = 1'b0;
            cmd_a = ~v[i].a;
            checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL arith%0d_early: res_valid=%b want 0", i, res_valid); end
            step();
            checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL arith%0d_valid: got %b want 1", i, res_valid); end
            checks++; if (res_out !== v[i].out) begin fails++; $display("FAIL arith%0d_out: got %h want %h", i, res_out, v[i].out); end
            checks++; if (res_status !== v[i].st) begin fails++; $display("FAIL arith%0d_status: got %b want %b", i, res_status, v[i].st); end
            checks++; if (res_cout !== v[i].cout || res_err !== 1'b0) begin
                fails++; $display("FAIL arith%0d_cout_err: cout=%b err=%b want %b/0", i, res_cout, res_err, v[i].cout);
            end
            checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL arith%0d_ready: got %b want 0", i, cmd_ready); end
            retire();
            checks++; if (res_valid !== 1'b0 || op_count !== exp_count) begin
                fails++; $display("FAIL arith%0d_retire: valid=%b count=%h want 0/%h", i, res_valid, op_count, exp_count);
            end
        end
    endtask

    typedef struct packed {
        logic [4:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] out;
        logic [3:0]  st;
        int          k;
    } shift_t;

    task automatic test_shift();
        shift_t v[5];
        int     cnt;
        v[0] = '{5'b11000, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000, 63};
        v[1] = '{5'b10100, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4'b0000, 4};
        v[2] = '{5'b10111, 64'hF0, 64'd4, 64'h0F, 4'b0000, 4};
        v[3] = '{5'b11000, 64'hDEAD, 64'd64, 64'hDEAD, 4'b0000, 0};
        v[4] = '{5'b10100, 64'd1, 64'd1, 64'd0, 4'b0010, 1};
        for (int i = 0; i < 5; i++) begin
            send(v[i].sel, v[i].a, v[i].b, 1'b1);
            step();
            cmd_valid = 1'b0;
            cmd_a = 64'h5555_AAAA_5555_AAAA;
            cmd_b = 64'd7;
            cnt = 0;
            while (res_valid !== 1'b1 && cnt < 200) begin
                step();
                cnt++;
            end
            checks++; if (cnt != v[i].k + 1) begin fails++; $display("FAIL shift%0d_latency: got %0d want %0d", i, cnt, v[i].k + 1); end
            checks++; if (res_out !== v[i].out) begin fails++; $display("FAIL shift%0d_out: got %h want %h", i, res_out, v[i].out); end
            checks++; if (res_status !== v[i].st || res_cout !== 1'b0) begin
                fails++; $display("FAIL shift%0d_flags: status=%b cout=%b want %b/0", i, res_status, res_cout, v[i].st);
            end
            retire();
        end
    endtask

    task automatic test_shift_reset();
        int cnt;
        send(5'b11000, 64'd1, 64'd63, 1'b0);
        step();
        cmd_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (res_valid === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin fails++; $display("FAIL shrst_early_valid: %0d valid cycles want 0", cnt); end
        rst_n = 1'b0;
        #2;
        exp_count = '0;
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== exp_count) begin
            fails++; $display("FAIL shrst_async: valid=%b ready=%b count=%h want 0/1/0", res_valid, cmd_ready, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (res_valid === 1'b1) cnt++;
        end
        checks++; if (cnt != 0 || op_count !== exp_count || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL shrst_discard: valid_cycles=%0d count=%h ready=%b want 0/%h/1", cnt, op_count, cmd_ready, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        send(5'b01100, 64'hDEAD, 64'hDEAD, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        checks++; if (res_valid !== 1'b1 || res_out !== 64'd0 || res_status !== 4'b0010) begin
            fails++; $display("FAIL b2b_xor: valid=%b out=%h status=%b want 1/0/0010", res_valid, res_out, res_status);
        end
        // Hold with a different command waiting; nothing must move.
        send(5'b10000, 64'd9, 64'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (res_valid !== 1'b1 || res_out !== 64'd0 || res_status !== 4'b0010 || cmd_ready !== 1'b0) begin
                fails++; $display("FAIL b2b_hold%0d: valid=%b out=%h status=%b ready=%b want 1/0/0010/0", i, res_valid, res_out, res_status, cmd_ready);
            end
        end
        checks++; if (op_count !== exp_count) begin fails++; $display("FAIL b2b_hold_count: got %h want %h", op_count, exp_count); end
        send(5'b10000, 64'd1, 64'd2, 1'b0);
        res_ready = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
        step();
        res_ready = 1'b0;
        exp_count = exp_count + 1'b1;
        // Scramble inputs while the new command executes.
        send(5'b11100, 64'hFFFF, 64'hFFFF, 1'b1);
        cmd_valid = 1'b0;
        checks++; if (res_valid !== 1'b0 || op_count !== exp_count) begin
            fails++; $display("FAIL b2b_accept: valid=%b count=%h want 0/%h", res_valid, op_count, exp_count);
        end
        step();
        checks++; if (res_valid !== 1'b1 || res_out !== 64'd3 || res_err !== 1'b0) begin
            fails++; $display("FAIL b2b_second: valid=%b out=%h err=%b want 1/3/0", res_valid, res_out, res_err);
        end
        retire();
    endtask

    task automatic test_illegal_wrap();
        logic [4:0] bad_sel[2];
        int         guard;
        bad_sel[0] = 5'b00000;
        bad_sel[1] = 5'b11111;
        for (int i = 0; i < 2; i++) begin
            send(bad_sel[i], 64'h8000_0000_0000_0000, 64'h3F, 1'b1);
            step();
            cmd_valid = 1'b0;
            step();
            checks++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin
                fails++; $display("FAIL illegal%0d_err: valid=%b err=%b want 1/1", i, res_valid, res_err);
            end
            checks++; if (res_out !== 64'd0 || res_status !== 4'b0000 || res_cout !== 1'b0) begin
                fails++; $display("FAIL illegal%0d_out: out=%h status=%b cout=%b want 0", i, res_out, res_status, res_cout);
            end
            retire();
        end
        guard = 0;
        while (exp_count != {CNT_W{1'b1}} && guard < 400) begin
            send(5'b00000, 64'd0, 64'd0, 1'b0);
            step();
            cmd_valid = 1'b0;
            step();
            retire();
            guard++;
        end
        checks++; if (op_count !== {CNT_W{1'b1}}) begin fails++; $display("FAIL wrap_full: got %h want %h", op_count, {CNT_W{1'b1}}); end
        send(5'b00000, 64'd0, 64'd0, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        retire();
        checks++; if (op_count !== '0 || exp_count !== '0) begin
            fails++; $display("FAIL wrap_zero: got %h want 0", op_count);
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        exp_count = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = 5'd0;
        cmd_a     = 64'd0;
        cmd_b     = 64'd0;
        cmd_cin   = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_arith();
        test_shift();
        test_shift_reset();
        test_back_to_back();
        test_illegal_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
